// File: rtl/la_ioanalog_mux.sv
// Analog pad mux: routes one pad onto one of N core taps through break-before-make switches.
// Optional build macro LA_IOANALOG_DISCHARGE_EN inserts a pad discharge phase after the break.
module la_ioanalog_mux #(
  parameter TYPE = "DEFAULT",
  parameter SIDE = "NO",
  parameter int RINGW = 8,
  parameter int N = 4,
  parameter int SELW = $clog2(N),
  parameter int BREAKCYC = 2,
  parameter int SETTLECYC = 8,
  parameter int DSCHGCYC = 4
) (
  input  logic            clk,
  input  logic            nreset,
  inout  wire             pad,
  inout  wire             vdd,
  inout  wire             vss,
  inout  wire             vddio,
  inout  wire             vssio,
  inout  wire [RINGW-1:0] ioring,
  inout  wire [N-1:0]     aio,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_en,
  input  logic [SELW-1:0] req_sel,
  output logic [N-1:0]    sw_en,
  output logic [SELW-1:0] active_sel,
  output logic            connected,
  output logic            done,
  output logic            err,
  output logic            dschg
);

  localparam int MAXBS  = (BREAKCYC > SETTLECYC) ? BREAKCYC : SETTLECYC;
  localparam int MAXCYC = (MAXBS > DSCHGCYC) ? MAXBS : DSCHGCYC;
  localparam int CNTW   = $clog2(MAXCYC + 1);
  localparam logic [CNTW-1:0] BREAK_LD  = CNTW'(BREAKCYC - 1);
  localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLECYC - 1);
`ifdef LA_IOANALOG_DISCHARGE_EN
  localparam logic [CNTW-1:0] DSCHG_LD  = CNTW'(DSCHGCYC - 1);
`endif

  // Cell identity and supplies are structural only; keep them referenced.
  localparam int unused_cfg_bits = $bits(TYPE) + $bits(SIDE);
  wire unused_supplies = &{1'b0, vdd, vss, vddio, vssio, ioring};

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
`ifdef LA_IOANALOG_DISCHARGE_EN
    DSCHG,
`endif
    SETTLE
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            cap_en, cap_en_nxt;
  logic [SELW-1:0] cap_sel, cap_sel_nxt;
  logic [N-1:0]    sw_en_nxt;
  logic [SELW-1:0] active_sel_nxt;
  logic            connected_nxt, done_nxt, err_nxt;
  logic            open_end;

  function automatic logic sel_valid(input logic [SELW-1:0] s);
    return 32'(s) < 32'(N);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SELW-1:0] s);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if (32'(s) == 32'(k)) v[k] = 1'b1;
    return v;
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_sw
    assign aio[k] = sw_en[k] ? pad : 1'bz;
  end

  assign req_ready = (state == IDLE);

`ifdef LA_IOANALOG_DISCHARGE_EN
  logic dschg_nxt;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) dschg <= 1'b0;
    else         dschg <= dschg_nxt;
`else
  assign dschg = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_en     <= 1'b0;
      cap_sel    <= '0;
      sw_en      <= '0;
      active_sel <= '0;
      connected  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cap_en     <= cap_en_nxt;
      cap_sel    <= cap_sel_nxt;
      sw_en      <= sw_en_nxt;
      active_sel <= active_sel_nxt;
      connected  <= connected_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cap_en_nxt     = cap_en;
    cap_sel_nxt    = cap_sel;
    sw_en_nxt      = sw_en;
    active_sel_nxt = active_sel;
    connected_nxt  = connected;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    open_end       = 1'b0;
`ifdef LA_IOANALOG_DISCHARGE_EN
    dschg_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_en && !sel_valid(req_sel)) begin
            err_nxt = 1'b1;
          end else if (req_en && connected && req_sel == active_sel) begin
            done_nxt = 1'b1;
          end else begin
            // Break first: every switch opens before any new make.
            state_nxt     = BREAK;
            cnt_nxt       = BREAK_LD;
            sw_en_nxt     = '0;
            connected_nxt = 1'b0;
            cap_en_nxt    = req_en;
            cap_sel_nxt   = req_sel;
          end
        end
      end
      BREAK: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
`ifdef LA_IOANALOG_DISCHARGE_EN
          state_nxt = DSCHG;
          cnt_nxt   = DSCHG_LD;
          dschg_nxt = 1'b1;
`else
          open_end  = 1'b1;
`endif
        end
      end
`ifdef LA_IOANALOG_DISCHARGE_EN
      DSCHG: begin
        if (cnt != '0) begin
          cnt_nxt   = cnt - 1'b1;
          dschg_nxt = 1'b1;
        end else begin
          open_end  = 1'b1;
        end
      end
`endif
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt     = IDLE;
          connected_nxt = 1'b1;
          done_nxt      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // End of the open interval: make the captured tap, or finish a disconnect.
    if (open_end) begin
      if (cap_en) begin
        state_nxt      = SETTLE;
        cnt_nxt        = SETTLE_LD;
        sw_en_nxt      = onehot(cap_sel);
        active_sel_nxt = cap_sel;
      end else begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end
  end

endmodule
